// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_pkg
// Purpose  : Framing definitions shared by the serial transmitter, the
//            receiver and their benches: FSM state encodings, line levels
//            and the parity check helper.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_rx_pkg;

    // Receiver FSM states; encodings are fixed so the transmit side and
    // the benches can decode them consistently.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Line levels: the line idles high, a frame opens with a low start bit
    // and closes with a high stop bit.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // acc is the XOR of every data bit and the received parity bit.
    // Even parity leaves that XOR at 0, odd parity at 1.
    function automatic logic parity_ok(input logic acc, input logic odd);
        return ((acc ^ odd) == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : Serial-input / parallel-output bundle of the frame receiver.
//            master = the side driving the line (serializer or bench),
//            slave  = the receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             sin;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output enable, sin,
        input  data_out, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  enable, sin,
        output data_out, valid, parity_err, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx_parity_acc.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_acc
// Purpose  : 1-bit running XOR accumulator with synchronous clear and
//            enable. Clear has priority over accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_acc (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    input  wire logic d,
    output logic      acc
);

    logic r_acc;

    // Running parity: clear at frame start, fold in each enabled bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= 1'b0;
        end else if (clr) begin
            r_acc <= 1'b0;
        end else if (en) begin
            r_acc <= r_acc ^ d;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Serial frame receiver. Samples one bit per enabled clock,
//            frames start / WIDTH data / optional parity / stop, and
//            presents the word with valid, parity_err and frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    serial_frame_rx_if.slave bus
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST_BIT = CW'(WIDTH - 1);
    localparam logic            C_ODD      = (PARITY_ODD != 0);

    rx_state_e        r_state;
    rx_state_e        w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_busy;

    logic             w_shift_en;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_acc_clr;
    logic             w_acc_en;
    logic             w_stop;
    logic             w_acc;
    logic             w_par_ok;

    // Bit order selects where each new bit enters the shift register.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], bus.sin};
        end else begin : g_lsb_first
            assign w_shift_next = {bus.sin, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Parity covers data bits and, when present, the parity bit itself.
    serial_parity_acc u_parity_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .d     (bus.sin),
        .acc   (w_acc)
    );

    assign w_par_ok = (PARITY_EN == 0) || parity_ok(w_acc, C_ODD);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes; nothing moves while enable is low.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        w_stop       = 1'b0;
        if (bus.enable) begin
            case (r_state)
                IDLE: begin
                    if (bus.sin == START_LEVEL) begin
                        w_state_next = DATA;
                        w_cnt_clr    = 1'b1;
                        w_acc_clr    = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    w_acc_en   = 1'b1;
                    if (r_cnt == C_LAST_BIT) begin
                        w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                PARITY: begin
                    w_acc_en     = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_stop       = 1'b1;
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Shift register, bit counter, output word, status pulses and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= (w_state_next != IDLE);

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end

            // A low stop bit is a framing error and is not reused as a
            // start bit; the FSM always returns to IDLE from STOP.
            if (w_stop) begin
                if (bus.sin == IDLE_LEVEL) begin
                    if (w_par_ok) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                    end else begin
                        r_perr <= 1'b1;
                    end
                end else begin
                    r_ferr <= 1'b1;
                    r_perr <= ~w_par_ok;
                end
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
